data_cache_controller: RTL and testbench

Miss-handling and write-through sequencer between the memory-stage load/store port, the direct-mapped data cache (16 blocks x 16 words) and data memory. A read hit completes with zero stall. A read miss stalls the pipeline and refills the whole 64-byte block word by word from memory. Writes are write-through, no-write-allocate, and the block keeps saturating hit/miss counters.

---
 rtl/data_cache_controller.sv | 163 ++++++++++++++++
 tb/tb_data_cache_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_controller.sv
// Miss-handling and write-through sequencer between the memory-stage load/store port,
// a direct-mapped data cache and data memory; also keeps saturating hit/miss counters.
module data_cache_controller #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int OFFSET_BITS     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    input  logic        cache_hit,
    input  logic [31:0] cache_data,
    output logic [31:0] cache_address,
    output logic [31:0] cache_write_data,
    output logic        cache_write_enable,
    output logic        cache_fill,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(WORDS_PER_BLOCK - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [OFFSET_BITS-1:0] r_beat;
    logic [31:0]            r_addr;
    logic [31:0]            r_data;
    logic                   r_hit;
    logic [31:0]            r_hit_count;
    logic [31:0]            r_miss_count;
    logic                   w_count_hit;
    logic                   w_count_miss;
    logic [31:0]            w_block_addr;

    assign w_block_addr  = {r_addr[31:OFFSET_BITS+2], r_beat, 2'b00};
    assign cpu_read_data = cache_data;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;

    // Outputs are forced low while reset is held so nothing leaks out of the IDLE decode.
    always_comb begin
        w_next_state       = r_state;
        w_count_hit        = 1'b0;
        w_count_miss       = 1'b0;
        cpu_stall          = 1'b0;
        cache_address      = 32'd0;
        cache_write_data   = 32'd0;
        cache_write_enable = 1'b0;
        cache_fill         = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_address        = 32'd0;
        mem_write_data     = 32'd0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    cache_address = cpu_address;
                    if (cpu_write) begin
                        cpu_stall    = 1'b1;
                        w_next_state = WRITE;
                        w_count_hit  = cache_hit;
                        w_count_miss = !cache_hit;
                    end else if (cpu_read) begin
                        if (cache_hit) begin
                            w_count_hit = 1'b1;
                        end else begin
                            cpu_stall    = 1'b1;
                            w_count_miss = 1'b1;
                            w_next_state = REFILL;
                        end
                    end
                end
                REFILL: begin
                    cpu_stall     = 1'b1;
                    mem_read      = 1'b1;
                    mem_address   = w_block_addr;
                    cache_address = w_block_addr;
                    if (mem_ready) begin
                        cache_fill         = 1'b1;
                        cache_write_enable = 1'b1;
                        cache_write_data   = mem_read_data;
                        if (r_beat == LAST_BEAT) begin
                            w_next_state = DONE;
                        end
                    end
                end
                WRITE: begin
                    // The cache must see the store address so a write hit updates the right word.
                    cpu_stall      = 1'b1;
                    mem_write      = 1'b1;
                    mem_address    = {r_addr[31:2], 2'b00};
                    mem_write_data = r_data;
                    cache_address  = r_addr;
                    if (mem_ready) begin
                        w_next_state = DONE;
                        if (r_hit) begin
                            cache_write_enable = 1'b1;
                            cache_write_data   = r_data;
                        end
                    end
                end
                DONE: begin
                    cache_address = r_addr;
                    w_next_state  = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_addr  <= 32'd0;
            r_data  <= 32'd0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && (cpu_write || (cpu_read && !cache_hit))) begin
                r_addr <= cpu_address;
                r_beat <= '0;
            end
            if (r_state == IDLE && cpu_write) begin
                r_data <= cpu_write_data;
                r_hit  <= cache_hit;
            end
            if (r_state == REFILL && mem_ready) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_count_hit && r_hit_count != 32'hFFFF_FFFF) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_count_miss && r_miss_count != 32'hFFFF_FFFF) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a small direct-mapped cache model
// and a memory that returns 0x1000 + word offset.
module tb_data_cache_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpuRead;
    logic        cpuWrite;
    logic [31:0] cpuAddress;
    logic [31:0] cpuWriteData;
    logic [31:0] cpuReadData;
    logic        cpuStall;
    logic        cacheHit;
    logic [31:0] cacheData;
    logic [31:0] cacheAddress;
    logic [31:0] cacheWriteData;
    logic        cacheWriteEnable;
    logic        cacheFill;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memReady;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    int passCount  = 0;
    int totalCount = 0;

    int          stalls;
    int          beats;
    int          cacheWrites;
    int          cacheFills;
    int          memWrites;
    logic [31:0] readData;

    always #5 clock = ~clock;

    data_cache_controller dut (
        .clock              (clock),
        .reset              (reset),
        .cpu_read           (cpuRead),
        .cpu_write          (cpuWrite),
        .cpu_address        (cpuAddress),
        .cpu_write_data     (cpuWriteData),
        .cpu_read_data      (cpuReadData),
        .cpu_stall          (cpuStall),
        .cache_hit          (cacheHit),
        .cache_data         (cacheData),
        .cache_address      (cacheAddress),
        .cache_write_data   (cacheWriteData),
        .cache_write_enable (cacheWriteEnable),
        .cache_fill         (cacheFill),
        .mem_read           (memRead),
        .mem_write          (memWrite),
        .mem_address        (memAddress),
        .mem_write_data     (memWriteData),
        .mem_read_data      (memReadData),
        .mem_ready          (memReady),
        .hit_count          (hitCount),
        .miss_count         (missCount)
    );

    // Cache model: 16 blocks x 16 words, index [9:6], word [5:2], tag [31:10].
    logic [31:0] cacheMem [16][16];
    logic [15:0] cacheValid;
    logic [21:0] cacheTag [16];
    logic [3:0]  cacheIdx;
    logic [3:0]  cacheWord;

    assign cacheIdx    = cacheAddress[9:6];
    assign cacheWord   = cacheAddress[5:2];
    assign cacheHit    = cacheValid[cacheIdx] && (cacheTag[cacheIdx] == cacheAddress[31:10]);
    assign cacheData   = cacheMem[cacheIdx][cacheWord];
    assign memReadData = 32'h1000 | {28'd0, memAddress[5:2]};

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cacheValid <= '0;
        end else begin
            if (cacheWriteEnable) cacheMem[cacheIdx][cacheWord] <= cacheWriteData;
            if (cacheFill) begin
                cacheValid[cacheIdx] <= 1'b1;
                cacheTag[cacheIdx]   <= cacheAddress[31:10];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Runs one request to completion; memory answers after `delay` wait cycles per beat.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int delay, input logic [31:0] base);
        int waitCnt = 0;
        logic timedOut = 1'b0;
        stalls = 0; beats = 0; cacheWrites = 0; cacheFills = 0; memWrites = 0;
        @(negedge clock);
        cpuRead = rd; cpuWrite = wr; cpuAddress = addr; cpuWriteData = wdata; memReady = 1'b0;
        while (1) begin
            #1;
            memReady = (memRead || memWrite) ? (waitCnt >= delay) : 1'b0;
            #1;
            if (!cpuStall) break;
            if (cacheWriteEnable) cacheWrites++;
            if (cacheFill) cacheFills++;
            if (memRead && memReady) begin
                checkOutput("refill_addr", memAddress, base + 32'(beats * 4));
                beats++;
            end
            if (memWrite && memReady) begin
                memWrites++;
                checkOutput("write_mem_addr", memAddress, {addr[31:2], 2'b00});
                checkOutput("write_mem_data", memWriteData, wdata);
            end
            if (wr && cacheWriteEnable) checkOutput("write_cache_data", cacheWriteData, wdata);
            if (memRead || memWrite) waitCnt = memReady ? 0 : waitCnt + 1;
            stalls++;
            if (stalls > 200) begin
                timedOut = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkOutput("stall_bound", {31'd0, timedOut}, 32'd0);
        readData = cpuReadData;
        @(posedge clock);
        #1;
        cpuRead = 1'b0; cpuWrite = 1'b0; memReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; cpuRead = 1'b1; cpuWrite = 1'b0; cpuAddress = 32'h123;
        cpuWriteData = 32'd0; memReady = 1'b0;
        #12;
        checkOutput("reset_stall", {31'd0, cpuStall}, 32'd0);
        checkOutput("reset_cache_addr", cacheAddress, 32'd0);
        checkOutput("reset_mem_read", {31'd0, memRead}, 32'd0);
        checkOutput("reset_hit_count", hitCount, 32'd0);
        checkOutput("reset_miss_count", missCount, 32'd0);
        cpuRead = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Read miss with memory ready every cycle
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 0, 32'h40);
        checkOutput("miss_stalls", 32'(stalls), 32'd17);
        checkOutput("miss_beats", 32'(beats), 32'd16);
        checkOutput("miss_fills", 32'(cacheFills), 32'd16);
        checkOutput("miss_done_data", readData, 32'h1000);
        checkOutput("miss_count1", missCount, 32'd1);
        checkOutput("hit_count0", hitCount, 32'd0);

        // Read hit in the freshly filled block
        applyStimulus(1'b1, 1'b0, 32'h7C, 32'd0, 0, 32'h0);
        checkOutput("hit_stalls", 32'(stalls), 32'd0);
        checkOutput("hit_data", readData, 32'h100F);
        checkOutput("hit_count1", hitCount, 32'd1);

        // Write hit with three memory wait cycles
        applyStimulus(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, 3, 32'h0);
        checkOutput("wr_hit_stalls", 32'(stalls), 32'd5);
        checkOutput("wr_hit_cache_writes", 32'(cacheWrites), 32'd1);
        checkOutput("wr_hit_fills", 32'(cacheFills), 32'd0);
        checkOutput("wr_hit_mem_writes", 32'(memWrites), 32'd1);
        checkOutput("hit_count2", hitCount, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h48, 32'd0, 0, 32'h0);
        checkOutput("readback_stalls", 32'(stalls), 32'd0);
        checkOutput("readback_data", readData, 32'hDEADBEEF);
        checkOutput("hit_count3", hitCount, 32'd3);

        // Write miss: no allocation
        applyStimulus(1'b0, 1'b1, 32'h1000, 32'h12345678, 0, 32'h0);
        checkOutput("wr_miss_stalls", 32'(stalls), 32'd2);
        checkOutput("wr_miss_cache_writes", 32'(cacheWrites), 32'd0);
        checkOutput("wr_miss_fills", 32'(cacheFills), 32'd0);
        checkOutput("wr_miss_mem_writes", 32'(memWrites), 32'd1);
        checkOutput("miss_count2", missCount, 32'd2);

        // Reset pulsed mid-refill at beat 7
        @(negedge clock);
        cpuRead = 1'b1; cpuAddress = 32'h200; memReady = 1'b1;
        repeat (8) @(negedge clock);
        #1;
        checkOutput("beat7_addr", memAddress, 32'h21C);
        checkOutput("miss_count3", missCount, 32'd3);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_stall", {31'd0, cpuStall}, 32'd0);
        checkOutput("rst_mid_mem_read", {31'd0, memRead}, 32'd0);
        checkOutput("rst_mid_mem_addr", memAddress, 32'd0);
        checkOutput("rst_mid_fill", {31'd0, cacheFill}, 32'd0);
        checkOutput("rst_mid_miss_count", missCount, 32'd0);
        cpuRead = 1'b0; memReady = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h200, 32'd0, 0, 32'h200);
        checkOutput("rerefill_stalls", 32'(stalls), 32'd17);
        checkOutput("rerefill_data", readData, 32'h1000);
        checkOutput("rerefill_miss_count", missCount, 32'd1);

        // Hit counter saturation
        @(negedge clock);
        force dut.r_hit_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_hit_count;
        #1;
        checkOutput("preload_hit_count", hitCount, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 1'b0, 32'h204, 32'd0, 0, 32'h0);
        checkOutput("sat_data", readData, 32'h1001);
        checkOutput("sat_hit1", hitCount, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 32'h208, 32'd0, 0, 32'h0);
        checkOutput("sat_hit2", hitCount, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 32'h20C, 32'd0, 0, 32'h0);
        checkOutput("sat_hit3", hitCount, 32'hFFFF_FFFF);
        checkOutput("sat_miss_count", missCount, 32'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
